// File: rtl/stage_pipeline_sequencer.sv
// stage_pipeline_sequencer
//   Top-level sequencer and resource arbiter for the image-compressor datapath.
//   Runs a UART load phase that ends after RX_TIMEOUT idle cycles, then fires
//   NUM_STAGES processing stages in order through an enable/finished handshake.
//   Only the active client drives the single SRAM port and the bank of
//   NUM_MULS shared signed multipliers.
//
//   Build option: define STAGE_WATCHDOG_EN to add a per-stage watchdog that
//   aborts a stage after WDOG_CYCLES cycles and raises the sticky wdog_error.
//
// Ports
//   CLOCK_50_I, resetn      clock, asynchronous active-low reset
//   start                   run request, sampled only while idle
//   uart_init, uart_enable  one-cycle UART control pulses
//   uart_sram_*             UART SRAM request bundle
//   stg_enable/finished     per-stage one-hot start pulse / completion pulse
//   stg_sram_*, stg_mul_*   packed per-stage SRAM requests and operands
//   mul_result              shared full-width signed products (combinational)
//   sram_*                  arbitrated SRAM port
//   active_stage, busy, done, wdog_error   status
module stage_pipeline_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int NUM_MULS    = 4,
  parameter int OP_W        = 32,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int RX_TIMEOUT  = 49999999,
  parameter int WDOG_CYCLES = 16777215
) (
  input  logic                             CLOCK_50_I,
  input  logic                             resetn,
  input  logic                             start,
  output logic                             uart_init,
  output logic                             uart_enable,
  input  logic [ADDR_W-1:0]                uart_sram_addr,
  input  logic [DATA_W-1:0]                uart_sram_wdata,
  input  logic                             uart_sram_we_n,
  output logic [NUM_STAGES-1:0]            stg_enable,
  input  logic [NUM_STAGES-1:0]            stg_finished,
  input  logic [NUM_STAGES*ADDR_W-1:0]     stg_sram_addr,
  input  logic [NUM_STAGES*DATA_W-1:0]     stg_sram_wdata,
  input  logic [NUM_STAGES-1:0]            stg_sram_we_n,
  input  logic [NUM_STAGES*NUM_MULS*OP_W-1:0] stg_mul_a,
  input  logic [NUM_STAGES*NUM_MULS*OP_W-1:0] stg_mul_b,
  output logic [NUM_MULS*2*OP_W-1:0]       mul_result,
  output logic [ADDR_W-1:0]                sram_addr,
  output logic [DATA_W-1:0]                sram_wdata,
  output logic                             sram_we_n,
  output logic [2:0]                       active_stage,
  output logic                             busy,
  output logic                             done,
  output logic                             wdog_error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_START = 3'd1,
    S_RX_WAIT  = 3'd2,
    S_STAGE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [2:0]            LAST_IDX  = 3'(NUM_STAGES - 1);
  localparam logic [31:0]           RX_LIMIT  = 32'(RX_TIMEOUT);
  localparam logic [NUM_STAGES-1:0] STG_FIRST = NUM_STAGES'(1);

  // Sign-extend an operand to product width so the multiply keeps every bit.
  function automatic logic [2*OP_W-1:0] sext(input logic [OP_W-1:0] v);
    return {{OP_W{v[OP_W-1]}}, v};
  endfunction

  state_t                  state_r, state_n;
  logic [2:0]              stage_idx_r, stage_idx_n;
  logic [31:0]             rx_timer_r, rx_timer_n, rx_inc_s;
  logic                    uart_init_r, uart_init_n;
  logic                    uart_enable_r, uart_enable_n;
  logic [NUM_STAGES-1:0]   stg_enable_r, stg_enable_n;
  logic                    done_r, done_n;
  logic                    busy_r;
  logic                    fin_s;
  logic [OP_W-1:0]         op_a_s [NUM_MULS];
  logic [OP_W-1:0]         op_b_s [NUM_MULS];

`ifdef STAGE_WATCHDOG_EN
  localparam logic [31:0]  WDOG_LIMIT = 32'(WDOG_CYCLES);
  logic [31:0]             wdog_cnt_r, wdog_cnt_n;
  logic                    wdog_error_r;
  logic                    wdog_hit_s, wdog_set_s;

  // Counter holds the number of cycles the current stage has been active,
  // counting its enable cycle as 1; the trip fires as it reaches the limit.
  assign wdog_hit_s = ((wdog_cnt_r + 32'd1) == WDOG_LIMIT);
`endif

  assign rx_inc_s = rx_timer_r + 32'd1;

  // Finished of the active stage only; a finish during its own enable cycle is dropped.
  always_comb begin
    fin_s = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      fin_s = fin_s | ((stage_idx_r == 3'(i)) & stg_finished[i] & ~stg_enable_r[i]);
    end
  end

  // Next-state and registered-pulse decode.
  always_comb begin
    state_n       = state_r;
    stage_idx_n   = stage_idx_r;
    rx_timer_n    = 32'd0;
    uart_init_n   = 1'b0;
    uart_enable_n = 1'b0;
    stg_enable_n  = '0;
    done_n        = 1'b0;
`ifdef STAGE_WATCHDOG_EN
    wdog_set_s    = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        if (start) begin
          uart_init_n = 1'b1;
          state_n     = S_RX_START;
        end else begin
          state_n     = S_IDLE;
        end
      end
      S_RX_START: begin
        uart_enable_n = 1'b1;
        state_n       = S_RX_WAIT;
      end
      S_RX_WAIT: begin
        // Transition happens on the edge that loads the limit into the timer,
        // so the first enable lands RX_TIMEOUT+1 cycles after the last write.
        if (uart_init_r || !uart_sram_we_n) begin
          rx_timer_n = 32'd0;
        end else if (rx_inc_s == RX_LIMIT) begin
          uart_init_n  = 1'b1;
          stage_idx_n  = 3'd0;
          stg_enable_n = STG_FIRST;
          state_n      = S_STAGE;
        end else begin
          rx_timer_n   = rx_inc_s;
        end
      end
      S_STAGE: begin
        if (fin_s) begin
          if (stage_idx_r < LAST_IDX) begin
            stage_idx_n  = stage_idx_r + 3'd1;
            stg_enable_n = STG_FIRST << (stage_idx_r + 3'd1);
          end else begin
            state_n      = S_DONE;
          end
`ifdef STAGE_WATCHDOG_EN
        end else if (wdog_hit_s) begin
          wdog_set_s = 1'b1;
          state_n    = S_IDLE;
`endif
        end else begin
          state_n = S_STAGE;
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

`ifdef STAGE_WATCHDOG_EN
  // Watchdog counter restarts with every stage enable.
  always_comb begin
    if (stg_enable_n != '0) begin
      wdog_cnt_n = 32'd1;
    end else if (state_r == S_STAGE) begin
      wdog_cnt_n = wdog_cnt_r + 32'd1;
    end else begin
      wdog_cnt_n = 32'd0;
    end
  end

  // Watchdog state; the error flag only clears on reset.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_r   <= 32'd0;
      wdog_error_r <= 1'b0;
    end else begin
      wdog_cnt_r   <= wdog_cnt_n;
      wdog_error_r <= wdog_error_r | wdog_set_s;
    end
  end

  assign wdog_error = wdog_error_r;
`else
  assign wdog_error = 1'b0;
`endif

  // Sequencer state and pulse registers.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_r       <= S_IDLE;
      stage_idx_r   <= 3'd0;
      rx_timer_r    <= 32'd0;
      uart_init_r   <= 1'b0;
      uart_enable_r <= 1'b0;
      stg_enable_r  <= '0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      stage_idx_r   <= stage_idx_n;
      rx_timer_r    <= rx_timer_n;
      uart_init_r   <= uart_init_n;
      uart_enable_r <= uart_enable_n;
      stg_enable_r  <= stg_enable_n;
      done_r        <= done_n;
      // busy stays up through the done pulse and falls the cycle after it.
      busy_r        <= (state_n != S_IDLE) | done_n;
    end
  end

  // SRAM and operand routing from the registered state.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    for (int m = 0; m < NUM_MULS; m++) begin
      op_a_s[m] = '0;
      op_b_s[m] = '0;
    end
    case (state_r)
      S_RX_START, S_RX_WAIT: begin
        sram_addr  = uart_sram_addr;
        sram_wdata = uart_sram_wdata;
        sram_we_n  = uart_sram_we_n;
      end
      S_STAGE: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (stage_idx_r == 3'(i)) begin
            sram_addr  = stg_sram_addr[i*ADDR_W +: ADDR_W];
            sram_wdata = stg_sram_wdata[i*DATA_W +: DATA_W];
            sram_we_n  = stg_sram_we_n[i];
            for (int m = 0; m < NUM_MULS; m++) begin
              op_a_s[m] = stg_mul_a[(i*NUM_MULS+m)*OP_W +: OP_W];
              op_b_s[m] = stg_mul_b[(i*NUM_MULS+m)*OP_W +: OP_W];
            end
          end else begin
            sram_we_n = sram_we_n;
          end
        end
      end
      default: begin
        sram_we_n = 1'b1;
      end
    endcase
  end

  // Shared signed multipliers, full-width products.
  always_comb begin
    mul_result = '0;
    for (int m = 0; m < NUM_MULS; m++) begin
      mul_result[m*2*OP_W +: 2*OP_W] = sext(op_a_s[m]) * sext(op_b_s[m]);
    end
  end

  assign uart_init    = uart_init_r;
  assign uart_enable  = uart_enable_r;
  assign stg_enable   = stg_enable_r;
  assign done         = done_r;
  assign busy         = busy_r;
  assign active_stage = (state_r == S_STAGE) ? stage_idx_r : 3'd0;

endmodule

// File: tb/tb_stage_pipeline_sequencer.sv
// Directed self-checking bench for stage_pipeline_sequencer.
// Build with STAGE_WATCHDOG_EN defined to exercise the watchdog path.
module tb_stage_pipeline_sequencer;

  localparam int NS   = 3;
  localparam int NM   = 4;
  localparam int OW   = 32;
  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int RXTO = 200;
  localparam int WDOG = 100;

  logic                CLOCK_50_I = 1'b0;
  logic                resetn, start;
  logic                uart_init, uart_enable;
  logic [AW-1:0]       uart_sram_addr;
  logic [DW-1:0]       uart_sram_wdata;
  logic                uart_sram_we_n;
  logic [NS-1:0]       stg_enable, stg_finished, stg_sram_we_n;
  logic [NS*AW-1:0]    stg_sram_addr;
  logic [NS*DW-1:0]    stg_sram_wdata;
  logic [NS*NM*OW-1:0] stg_mul_a, stg_mul_b;
  logic [NM*2*OW-1:0]  mul_result;
  logic [AW-1:0]       sram_addr;
  logic [DW-1:0]       sram_wdata;
  logic                sram_we_n;
  logic [2:0]          active_stage;
  logic                busy, done, wdog_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int init_cnt = 0, uen_cnt = 0, done_cnt = 0;
  int last_write_cyc = 0, enable0_cyc = 0;
  bit ok;

  stage_pipeline_sequencer #(
    .NUM_STAGES(NS), .NUM_MULS(NM), .OP_W(OW), .ADDR_W(AW), .DATA_W(DW),
    .RX_TIMEOUT(RXTO), .WDOG_CYCLES(WDOG)
  ) dut (
    .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .start(start),
    .uart_init(uart_init), .uart_enable(uart_enable),
    .uart_sram_addr(uart_sram_addr), .uart_sram_wdata(uart_sram_wdata),
    .uart_sram_we_n(uart_sram_we_n),
    .stg_enable(stg_enable), .stg_finished(stg_finished),
    .stg_sram_addr(stg_sram_addr), .stg_sram_wdata(stg_sram_wdata),
    .stg_sram_we_n(stg_sram_we_n),
    .stg_mul_a(stg_mul_a), .stg_mul_b(stg_mul_b), .mul_result(mul_result),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_n(sram_we_n),
    .active_stage(active_stage), .busy(busy), .done(done), .wdog_error(wdog_error)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  // Event monitor, sampled mid-cycle.
  always @(negedge CLOCK_50_I) begin
    cyc <= cyc + 1;
    if (uart_init)          init_cnt <= init_cnt + 1;
    if (uart_enable)        uen_cnt <= uen_cnt + 1;
    if (done)               done_cnt <= done_cnt + 1;
    if (!uart_sram_we_n)    last_write_cyc <= cyc;
    if (stg_enable[0])      enable0_cyc <= cyc;
  end

  task automatic tick();
    @(posedge CLOCK_50_I);
    #2;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_up();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic wait_enable(output bit found);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (stg_enable != '0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    uart_sram_addr = '0; uart_sram_wdata = '0; uart_sram_we_n = 1'b1;
    stg_finished = '0;
    stg_sram_addr  = {20'hABCDE, 20'h12345, 20'h00001};
    stg_sram_wdata = {16'h3333, 16'h2222, 16'h1111};
    stg_sram_we_n  = 3'b101;
    stg_mul_a = '0; stg_mul_b = '0;
    stg_mul_a[(0*NM+2)*OW +: OW] = 32'hFFFF_FFFD;   // -3
    stg_mul_b[(0*NM+2)*OW +: OW] = 32'h0000_0007;   //  7
    stg_mul_a[(1*NM+2)*OW +: OW] = 32'h0000_0005;   //  5
    stg_mul_b[(1*NM+2)*OW +: OW] = 32'hFFFF_FFFA;   // -6
    stg_mul_a[(2*NM+0)*OW +: OW] = 32'h7FFF_FFFF;
    stg_mul_b[(2*NM+0)*OW +: OW] = 32'h7FFF_FFFF;
    stg_mul_a[(2*NM+3)*OW +: OW] = 32'h8000_0000;
    stg_mul_b[(2*NM+3)*OW +: OW] = 32'h8000_0000;

    repeat (3) tick();
    check_eq("rst_busy",      64'(busy), 64'd0);
    check_eq("rst_we_n",      64'(sram_we_n), 64'd1);
    check_eq("rst_addr",      64'(sram_addr), 64'd0);
    check_eq("rst_enable",    64'(stg_enable), 64'd0);
    check_eq("rst_pulses",    64'({uart_init, uart_enable, done}), 64'd0);
    check_eq("rst_active",    64'(active_stage), 64'd0);
    check_eq("rst_wdog",      64'(wdog_error), 64'd0);
    check_eq("rst_mul",       64'(mul_result[2*2*OW +: 2*OW]), 64'd0);
    resetn = 1'b1;
    tick();

    // UART load: 100 writes, one every 10 cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("init_pulse", 64'(uart_init), 64'd1);
    check_eq("busy_rise",  64'(busy), 64'd1);
    for (int w = 0; w < 100; w++) begin
      uart_sram_addr  = AW'(w + 256);
      uart_sram_wdata = DW'(w);
      uart_sram_we_n  = 1'b0;
      if (w == 5) begin
        #1;
        check_eq("uart_route_addr", 64'(sram_addr), 64'h105);
        check_eq("uart_route_we",   64'(sram_we_n), 64'd0);
      end
      tick();
      uart_sram_we_n = 1'b1;
      repeat (9) tick();
    end

    wait_enable(ok);
    if (!ok) begin
      check_eq("enable0_timeout", 64'd0, 64'd1);
      finish_up();
    end
    // Stage 0 enable cycle.
    check_eq("s0_enable", 64'(stg_enable), 64'b001);
    check_eq("s0_active", 64'(active_stage), 64'd0);
    check_eq("s0_addr",   64'(sram_addr), 64'h00001);
    check_eq("s0_we_n",   64'(sram_we_n), 64'd1);
    check_eq("s0_mul2",   64'(mul_result[2*2*OW +: 2*OW]), 64'hFFFF_FFFF_FFFF_FFEB);
    check_eq("s0_mul1",   64'(mul_result[1*2*OW +: 2*OW]), 64'd0);
    stg_finished = 3'b001;            // same cycle as enable: ignored
    tick();                           // cycle 2
    stg_finished = 3'b000;
    check_eq("init_count",   64'(init_cnt), 64'd2);
    check_eq("uen_count",    64'(uen_cnt), 64'd1);
    check_eq("rx_latency",   64'(enable0_cyc - last_write_cyc), 64'(RXTO + 1));
    check_eq("same_cyc_fin", 64'(active_stage), 64'd0);
    stg_finished = 3'b100;            // non-active stage
    tick();                           // cycle 3
    stg_finished = 3'b000;
    start = 1'b1;
    tick();                           // cycle 4
    start = 1'b0;
    check_eq("stray_fin_active", 64'(active_stage), 64'd0);
    check_eq("stray_fin_enable", 64'(stg_enable), 64'd0);
    repeat (47) tick();               // cycle 51 = enable + 50
    check_eq("start_ignored", 64'(init_cnt), 64'd2);
    stg_finished = 3'b001;
    tick();
    stg_finished = 3'b000;
    // Stage 1 enable cycle.
    check_eq("s1_enable", 64'(stg_enable), 64'b010);
    check_eq("s1_active", 64'(active_stage), 64'd1);
    check_eq("s1_addr",   64'(sram_addr), 64'h12345);
    check_eq("s1_we_n",   64'(sram_we_n), 64'd0);
    check_eq("s1_wdata",  64'(sram_wdata), 64'h2222);
    check_eq("s1_mul2",   64'(mul_result[2*2*OW +: 2*OW]), 64'hFFFF_FFFF_FFFF_FFE2);
    tick();                           // stage 1 cycle 2
    check_eq("s1_enable_pulse", 64'(stg_enable), 64'd0);

`ifdef STAGE_WATCHDOG_EN
    repeat (97) tick();               // stage 1 cycle 99
    check_eq("wdog_before", 64'(wdog_error), 64'd0);
    check_eq("busy_before", 64'(busy), 64'd1);
    tick();                           // stage 1 cycle 100
    check_eq("wdog_trip",   64'(wdog_error), 64'd1);
    check_eq("wdog_idle",   64'(busy), 64'd0);
    check_eq("wdog_we_n",   64'(sram_we_n), 64'd1);
    check_eq("wdog_active", 64'(active_stage), 64'd0);
    repeat (5) tick();
    check_eq("wdog_sticky", 64'(wdog_error), 64'd1);
    check_eq("wdog_no_done", 64'(done_cnt), 64'd0);
`else
    repeat (49) tick();               // stage 1 cycle 51 = enable + 50
    stg_finished = 3'b010;
    tick();
    stg_finished = 3'b000;
    check_eq("s2_enable", 64'(stg_enable), 64'b100);
    check_eq("s2_active", 64'(active_stage), 64'd2);
    check_eq("s2_addr",   64'(sram_addr), 64'hABCDE);
    check_eq("s2_we_n",   64'(sram_we_n), 64'd1);
    check_eq("s2_mul0",   64'(mul_result[0*2*OW +: 2*OW]), 64'h3FFF_FFFF_0000_0001);
    check_eq("s2_mul3",   64'(mul_result[3*2*OW +: 2*OW]), 64'h4000_0000_0000_0000);
    repeat (50) tick();
    stg_finished = 3'b100;
    tick();                           // finished + 1
    stg_finished = 3'b000;
    check_eq("done_f1",   64'(done), 64'd0);
    check_eq("busy_f1",   64'(busy), 64'd1);
    tick();                           // finished + 2
    check_eq("done_f2",   64'(done), 64'd1);
    check_eq("busy_f2",   64'(busy), 64'd1);
    check_eq("idle_we_n", 64'(sram_we_n), 64'd1);
    tick();                           // finished + 3
    check_eq("done_f3",   64'(done), 64'd0);
    check_eq("busy_f3",   64'(busy), 64'd0);
    check_eq("done_count", 64'(done_cnt), 64'd1);

    // Second run: stage 1 hangs and nothing aborts it.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_enable(ok);
    if (!ok) begin
      check_eq("enable0_timeout2", 64'd0, 64'd1);
      finish_up();
    end
    repeat (50) tick();
    stg_finished = 3'b001;
    tick();
    stg_finished = 3'b000;
    check_eq("run2_s1", 64'(active_stage), 64'd1);
    repeat (10000) tick();
    check_eq("hang_busy",   64'(busy), 64'd1);
    check_eq("hang_active", 64'(active_stage), 64'd1);
    check_eq("hang_wdog",   64'(wdog_error), 64'd0);
    check_eq("hang_done",   64'(done_cnt), 64'd1);
`endif
    finish_up();
  end

endmodule

// File: doc/stage_pipeline_sequencer.md
# stage_pipeline_sequencer

Parametrised top-level sequencer and resource arbiter for the image-compressor datapath. It is the successor to the fixed UART→CSCD→DCT controller. It runs a UART load phase with an idle timeout, then fires NUM_STAGES processing stages in order, each through an enable/finished handshake. Only the active client is routed onto the single SRAM port and the bank of NUM_MULS shared signed multipliers. An optional per-stage watchdog aborts a hung stage.

## Interface
Parameters:
- NUM_STAGES, 3, number of processing stages after UART load (1..8)
- NUM_MULS, 4, number of shared multipliers
- OP_W, 32, multiplier operand width; product is 2*OP_W
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- RX_TIMEOUT, 49999999, idle cycles on UART that end the load phase
- WDOG_CYCLES, 16777215, maximum cycles a stage may stay active (watchdog build only)

Ports:
- CLOCK_50_I  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  UART start-bit detect OR pushbutton; level sampled in S_IDLE
- uart_init  out  1  one-cycle UART initialise pulse
- uart_enable  out  1  one-cycle UART receive-enable pulse
- uart_sram_addr / uart_sram_wdata / uart_sram_we_n  in  ADDR_W / DATA_W / 1  UART SRAM request
- stg_enable  out  NUM_STAGES  one-hot, one-cycle start pulse per stage
- stg_finished  in  NUM_STAGES  per-stage completion pulse
- stg_sram_addr / stg_sram_wdata  in  NUM_STAGES*ADDR_W / NUM_STAGES*DATA_W  packed; stage i at slice i
- stg_sram_we_n  in  NUM_STAGES  per-stage write enable, active-low
- stg_mul_a / stg_mul_b  in  NUM_STAGES*NUM_MULS*OP_W  packed operands; stage i, multiplier m at slice i*NUM_MULS+m
- mul_result  out  NUM_MULS*2*OP_W  shared signed products, broadcast to all clients
- sram_addr / sram_wdata / sram_we_n  out  ADDR_W / DATA_W / 1  to SRAM controller
- active_stage  out  3  index of the running stage; 0 when no stage is running
- busy  out  1  high in any state except S_IDLE
- done  out  1  one-cycle pulse when the last stage finishes
- wdog_error  out  1  sticky watchdog flag

## Operation
- States: S_IDLE, S_RX_START, S_RX_WAIT, S_STAGE, S_DONE.
- S_IDLE: if start=1, pulse uart_init and go to S_RX_START.
- S_RX_START: pulse uart_enable; go to S_RX_WAIT.
- S_RX_WAIT: rx_timer clears on uart_init or uart_sram_we_n=0; otherwise it increments. When rx_timer==RX_TIMEOUT: pulse uart_init, set stage_idx=0, pulse stg_enable[0], go to S_STAGE.
- S_STAGE:
  - If stg_finished[stage_idx]=1 and stage_idx<NUM_STAGES-1: increment stage_idx, pulse the next stg_enable, stay in S_STAGE.
  - If the last stage finishes: go to S_DONE.
- S_DONE: pulse done; go to S_IDLE.
- Routing is combinational from registered state:
  - S_RX_START / S_RX_WAIT: the UART bundle drives the SRAM port.
  - S_STAGE: slice stage_idx drives the SRAM port and all multiplier operands.
  - All other states: sram_addr=0, sram_wdata=0, sram_we_n=1, operands=0.
- Products: mul_result[m] = signed(op_a[m]) * signed(op_b[m]), full 2*OP_W width, no truncation.
- Ignored events:
  - stg_finished from any non-active stage.
  - start while busy.
  - finished arriving in the same cycle as enable: the stage is still entered and that finished is ignored.

## Timing
- Reset values:
  - state=S_IDLE, stage_idx=0, rx_timer=0, watchdog counter=0.
  - All pulse outputs 0; busy=0, active_stage=0, wdog_error=0.
  - sram_we_n=1.
- Pulse and handshake latency:
  - stg_enable[i+1] is asserted the cycle after stg_finished[i] is sampled high (1-cycle handoff).
  - done is asserted 2 cycles after the last finished.
  - Stage k's mux slice is live from the cycle its enable is high.
- Multiplier path: zero-latency combinational; clients register products themselves.
- Reset mid-operation: asynchronous return to S_IDLE; SRAM write is deasserted immediately.

## Configuration
- STAGE_WATCHDOG_EN defined:
  - A 32-bit counter clears on every stg_enable pulse and increments while in S_STAGE.
  - When it reaches WDOG_CYCLES: set wdog_error, go to S_IDLE without a done pulse, release the SRAM port.
  - wdog_error clears only on reset.
- STAGE_WATCHDOG_EN undefined: no counter; wdog_error is tied to 0; a stage may run indefinitely.

## Test plan
- Reset, then start=1, UART writes every 10 cycles for 100 words, then silence. Required: stg_enable[0] pulses exactly RX_TIMEOUT+1 cycles after the last write; uart_init pulses twice in total.
- NUM_STAGES=3; each stage returns finished 50 cycles after its enable. Required: one-hot enables 0,1,2 at 1-cycle handoffs; done pulses once; busy falls on the cycle after done.
- Stage 1 active; stage 1 drives addr 0x12345, we_n=0; stage 0 drives addr 0x00001. Required: sram_addr=0x12345, sram_we_n=0.
- Stage 0 operand A=-3, B=7 on multiplier 2. Required: mul_result slice 2 = -21 in 64-bit two's complement.
- stg_finished[2] pulsed while stage 0 is active. Required: no state change. Also, start pulsed mid-run: no uart_init pulse.
- STAGE_WATCHDOG_EN with WDOG_CYCLES=100; stage 1 never finishes. Required: wdog_error=1 on the 100th cycle, return to S_IDLE, no done pulse. Without the macro: still in S_STAGE after 10000 cycles.
